// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte-stream handshake and line-status pulses of the UART
// receive front-end. Defining UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [$clog2(DEPTH):0] rx_count;
    logic                   frame_err;
    logic                   overflow;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err;
`endif

    // Receiver side: produces bytes and status, consumes the ready handshake.
    modport master (
        output rx_data, rx_valid, rx_count, frame_err, overflow,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        input  rx_ready
    );

    // Consumer side: the SoC byte-stream input.
    modport slave (
        input  rx_data, rx_valid, rx_count, frame_err, overflow,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive front-end. Synchronises UART_RX into hclk,
// deserialises 8N1 frames with a mid-bit sampling baud counter and buffers
// bytes in a first-word-fall-through FIFO with a valid/ready interface.
// Optional macro UART_RX_PARITY_EN: adds an even-parity bit and parity_err.
module uart_rx_fifo #(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           hclk,
    input  logic           RESET,
    input  logic           UART_RX,
    uart_rx_fifo_if.master rx_if
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(DEPTH);

    localparam logic [CW-1:0] HALF_LOAD  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD   = CW'(DIV - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [2:0]             state_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic                   tick;
    logic                   stop_tick;
    logic                   parity_ok;
    logic                   push_req;
    logic                   push_ok;
    logic                   pop;

    logic [7:0]             mem [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            count_q;
    logic                   frame_err_q;
    logic                   overflow_q;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign tick      = (cnt_q == '0);
    assign stop_tick = (state_q == S_STOP) && tick;

`ifdef UART_RX_PARITY_EN
    logic parity_q;
    logic parity_err_q;
    assign parity_ok = ~^{parity_q, shift_q};
`else
    assign parity_ok = 1'b1;
`endif

    assign push_req = stop_tick && rxs && parity_ok;
    assign pop      = (count_q != '0) && rx_if.rx_ready;
    assign push_ok  = push_req && ((count_q < FULL_COUNT) || pop);

    // Synchroniser chain; idles high so reset never looks like a start bit.
    always_ff @(posedge hclk) begin
        if (RESET) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RX};
        end
    end

    // Frame FSM with the shared baud down-counter and LSB-first shifter.
    always_ff @(posedge hclk) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (!rxs) begin
                            cnt_q     <= BIT_LOAD;
                            bit_idx_q <= '0;
                            state_q   <= S_DATA;
                        end else begin
                            state_q   <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_q <= {rxs, shift_q[7:1]};
                        cnt_q   <= BIT_LOAD;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        parity_q <= rxs;
                        cnt_q    <= BIT_LOAD;
                        state_q  <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        state_q <= rxs ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge hclk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers and occupancy; a full FIFO accepts a push only alongside a pop.
    always_ff @(posedge hclk) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Single-cycle line-status pulses raised on the stop-bit sample.
    always_ff @(posedge hclk) begin
        if (RESET) begin
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= stop_tick && !rxs;
            overflow_q   <= push_req && !push_ok;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= stop_tick && rxs && !parity_ok;
`endif
        end
    end

    assign rx_if.rx_data   = mem[rd_ptr_q];
    assign rx_if.rx_valid  = (count_q != '0);
    assign rx_if.rx_count  = count_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overflow  = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo. Instance A uses the
// default parameters (DIV=434); instance B runs at 3 Mbaud (DIV=17) so the
// long FIFO-fill and reset sequences stay short.
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 50000000;
    localparam int BAUD_B = 3000000;
    localparam int DIV_A  = 434;
    localparam int DIV_B  = 17;
    localparam int LAT_A  = 4126;
    localparam int LAT_B  = 164;

    typedef struct {
        int         which;
        logic [7:0] data;
        logic       stop_bit;
        int         hold_low;
        logic       exp_push;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_lat;
    } vec_t;

    logic hclk = 1'b0;
    logic RESET;
    logic line_a;
    logic line_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int   n_ferr[2];
    int   n_ovf[2];
    int   n_vcyc[2];
    int   rise_cyc[2];
    int   start_cyc[2];
    logic prev_valid[2];

    vec_t vecs[7];

    uart_rx_fifo_if #(.DEPTH(16)) if_a ();
    uart_rx_fifo_if #(.DEPTH(16)) if_b ();

    uart_rx_fifo dut_a (
        .hclk    (hclk),
        .RESET   (RESET),
        .UART_RX (line_a),
        .rx_if   (if_a)
    );

    uart_rx_fifo #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD_B)
    ) dut_b (
        .hclk    (hclk),
        .RESET   (RESET),
        .UART_RX (line_b),
        .rx_if   (if_b)
    );

    // Free-running clock and posedge counter used for latency measurement.
    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    // Monitor just after each falling edge: records pops, pulses and valid rises.
    initial begin
        for (int k = 0; k < 2; k++) begin
            n_ferr[k] = 0; n_ovf[k] = 0; n_vcyc[k] = 0;
            rise_cyc[k] = 0; prev_valid[k] = 1'b0;
        end
    end

    always @(negedge hclk) begin
        #1;
        if (if_a.rx_valid && if_a.rx_ready) q_a.push_back(if_a.rx_data);
        if (if_b.rx_valid && if_b.rx_ready) q_b.push_back(if_b.rx_data);
        if (if_a.frame_err) n_ferr[0]++;
        if (if_b.frame_err) n_ferr[1]++;
        if (if_a.overflow)  n_ovf[0]++;
        if (if_b.overflow)  n_ovf[1]++;
        if (if_a.rx_valid)  n_vcyc[0]++;
        if (if_b.rx_valid)  n_vcyc[1]++;
        if (if_a.rx_valid && !prev_valid[0]) rise_cyc[0] = cyc;
        if (if_b.rx_valid && !prev_valid[1]) rise_cyc[1] = cyc;
        prev_valid[0] = if_a.rx_valid;
        prev_valid[1] = if_b.rx_valid;
    end

    // Watchdog so the bench always ends on its own.
    initial begin
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded 60000 cycles, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveLine(input int which, input logic v);
        if (which == 0) line_a = v;
        else            line_b = v;
    endtask

    function automatic int countOf(input int which);
        return (which == 0) ? int'(if_a.rx_count) : int'(if_b.rx_count);
    endfunction

    function automatic int poppedCount(input int which);
        return (which == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic int poppedByte(input int which, input int idx);
        if (which == 0) return (idx < q_a.size()) ? int'(q_a[idx]) : -1;
        return (idx < q_b.size()) ? int'(q_b[idx]) : -1;
    endfunction

    // Sends one frame starting at the current falling edge, then one idle bit.
    task automatic sendFrame(input int which, input logic [7:0] data,
                             input logic stop_bit, input int hold_low);
        int per;
        per = (which == 0) ? DIV_A : DIV_B;
        driveLine(which, 1'b0);
        start_cyc[which] = cyc;
        repeat (per) @(negedge hclk);
        for (int i = 0; i < 8; i++) begin
            driveLine(which, data[i]);
            repeat (per) @(negedge hclk);
        end
        driveLine(which, stop_bit);
        repeat (per) @(negedge hclk);
        if (!stop_bit) repeat (hold_low) @(negedge hclk);
        driveLine(which, 1'b1);
        repeat (per) @(negedge hclk);
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        int nb0, fe0, vc0, nb;
        nb0 = poppedCount(v.which);
        fe0 = n_ferr[v.which];
        vc0 = n_vcyc[v.which];
        sendFrame(v.which, v.data, v.stop_bit, v.hold_low);
        @(negedge hclk);
        nb = poppedCount(v.which) - nb0;
        checkOutput($sformatf("%s_bytes", tag), nb, v.exp_push ? 1 : 0);
        checkOutput($sformatf("%s_frame_err", tag), n_ferr[v.which] - fe0, v.exp_ferr);
        checkOutput($sformatf("%s_valid_cycles", tag), n_vcyc[v.which] - vc0, v.exp_push ? 1 : 0);
        checkOutput($sformatf("%s_count", tag), countOf(v.which), 0);
        if (v.exp_push) begin
            checkOutput($sformatf("%s_data", tag), poppedByte(v.which, nb0), int'(v.exp_data));
            checkOutput($sformatf("%s_latency", tag),
                        rise_cyc[v.which] - start_cyc[v.which], v.exp_lat);
        end
    endtask

    initial begin
        int s4, ov0, fe0;
        vec_t v;

        vecs[0] = '{0, 8'hA5, 1'b1, 0,    1'b1, 8'hA5, 0, LAT_A};
        vecs[1] = '{0, 8'h55, 1'b0, 2000, 1'b0, 8'h00, 1, 0};
        vecs[2] = '{0, 8'h81, 1'b1, 0,    1'b1, 8'h81, 0, LAT_A};
        vecs[3] = '{1, 8'hC3, 1'b1, 0,    1'b1, 8'hC3, 0, LAT_B};
        vecs[4] = '{1, 8'h00, 1'b1, 0,    1'b1, 8'h00, 0, LAT_B};
        vecs[5] = '{1, 8'hFF, 1'b0, 40,   1'b0, 8'h00, 1, 0};
        vecs[6] = '{1, 8'h6E, 1'b1, 0,    1'b1, 8'h6E, 0, LAT_B};

        line_a = 1'b1;
        line_b = 1'b1;
        if_a.rx_ready = 1'b1;
        if_b.rx_ready = 1'b1;
        RESET = 1'b1;
        repeat (4) @(negedge hclk);

        checkOutput("reset_a_valid",     int'(if_a.rx_valid),  0);
        checkOutput("reset_a_count",     int'(if_a.rx_count),  0);
        checkOutput("reset_a_frame_err", int'(if_a.frame_err), 0);
        checkOutput("reset_a_overflow",  int'(if_a.overflow),  0);
        checkOutput("reset_b_valid",     int'(if_b.rx_valid),  0);
        checkOutput("reset_b_count",     int'(if_b.rx_count),  0);
        RESET = 1'b0;
        repeat (3) @(negedge hclk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Short low glitch on the default-rate line must be rejected silently.
        s4  = q_a.size();
        fe0 = n_ferr[0];
        line_a = 1'b0;
        repeat (100) @(negedge hclk);
        line_a = 1'b1;
        repeat (400) @(negedge hclk);
        checkOutput("glitch_bytes",     q_a.size() - s4,  0);
        checkOutput("glitch_frame_err", n_ferr[0] - fe0,  0);
        checkOutput("glitch_count",     int'(if_a.rx_count), 0);
        v = '{0, 8'h3C, 1'b1, 0, 1'b1, 8'h3C, 0, LAT_A};
        applyStimulus("after_glitch", v);

        // Fill instance B with rx_ready low; the 17th byte overflows.
        if_b.rx_ready = 1'b0;
        s4  = q_b.size();
        ov0 = n_ovf[1];
        for (int b = 0; b < 16; b++) begin
            sendFrame(1, 8'(b), 1'b1, 0);
        end
        checkOutput("fill_count",    int'(if_b.rx_count), 16);
        checkOutput("fill_overflow", n_ovf[1] - ov0, 0);
        sendFrame(1, 8'h10, 1'b1, 0);
        checkOutput("ovf_count",    int'(if_b.rx_count), 16);
        checkOutput("ovf_pulses",   n_ovf[1] - ov0, 1);
        checkOutput("ovf_head",     int'(if_b.rx_data), 8'h00);
        checkOutput("ovf_no_pops",  q_b.size() - s4, 0);

        // Full FIFO: pop exactly on the stop-sample cycle of the next byte.
        fork
            sendFrame(1, 8'h11, 1'b1, 0);
            begin
                repeat (LAT_B - 1) @(negedge hclk);
                if_b.rx_ready = 1'b1;
                @(negedge hclk);
                if_b.rx_ready = 1'b0;
            end
        join
        checkOutput("simul_count",    int'(if_b.rx_count), 16);
        checkOutput("simul_overflow", n_ovf[1] - ov0, 1);
        checkOutput("simul_head",     int'(if_b.rx_data), 8'h01);

        if_b.rx_ready = 1'b1;
        for (int k = 0; k < 40 && if_b.rx_count != 0; k++) @(negedge hclk);
        repeat (2) @(negedge hclk);
        checkOutput("drain_count",  int'(if_b.rx_count), 0);
        checkOutput("drain_popped", q_b.size() - s4, 17);
        for (int k = 0; k < 17; k++) begin
            checkOutput($sformatf("drain_byte%0d", k), poppedByte(1, s4 + k),
                        (k < 16) ? k : 8'h11);
        end

        // Reset halfway through the data bits of 0xF0 with one byte buffered.
        if_b.rx_ready = 1'b0;
        sendFrame(1, 8'h5A, 1'b1, 0);
        checkOutput("pre_reset_count", int'(if_b.rx_count), 1);
        s4  = q_b.size();
        fe0 = n_ferr[1];
        line_b = 1'b0;
        repeat (DIV_B) @(negedge hclk);
        for (int i = 0; i < 4; i++) begin
            line_b = 1'b0;
            repeat (DIV_B) @(negedge hclk);
        end
        line_b = 1'b1;
        RESET = 1'b1;
        @(negedge hclk);
        RESET = 1'b0;
        checkOutput("midreset_count",     int'(if_b.rx_count),  0);
        checkOutput("midreset_valid",     int'(if_b.rx_valid),  0);
        checkOutput("midreset_frame_err", int'(if_b.frame_err), 0);
        checkOutput("midreset_overflow",  int'(if_b.overflow),  0);
        repeat (DIV_B - 1) @(negedge hclk);
        repeat (4 * DIV_B) @(negedge hclk);
        checkOutput("midreset_tail_count",     int'(if_b.rx_count), 0);
        checkOutput("midreset_tail_frame_err", n_ferr[1] - fe0, 0);
        if_b.rx_ready = 1'b1;
        v = '{1, 8'h0F, 1'b1, 0, 1'b1, 8'h0F, 0, LAT_B};
        applyStimulus("after_reset", v);
        checkOutput("after_reset_total", q_b.size() - s4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receive front-end that sits between the board UART_RX pin and the loopback SoC's byte-stream input. It synchronises the asynchronous serial line into the hclk domain and deserialises 8N1 frames using a mid-bit sampling baud counter. Received bytes are buffered in a first-word-fall-through FIFO and presented on a valid/ready interface. Line errors are reported as single-cycle pulses.

Parameters:
CLK_HZ, 50000000, hclk frequency in Hz
BAUD, 115200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD (434 at defaults)
DEPTH, 16, FIFO entries; power of 2, minimum 2
SYNC_STAGES, 2, flops in the UART_RX synchroniser; minimum 2

Ports:
hclk  in  1  system clock
RESET  in  1  reset; synchronous, active-high
UART_RX  in  1  asynchronous serial input, idle high
rx_data  out  8  byte at FIFO head
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts; pop on rx_valid & rx_ready
rx_count  out  $clog2(DEPTH)+1  current FIFO occupancy
frame_err  out  1  one-cycle pulse: stop bit sampled 0
overflow  out  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
- Reset: synchroniser flops = 1; FSM = IDLE; FIFO empty; rx_valid=0, rx_count=0, frame_err=0, overflow=0. rx_data is don't-care while rx_valid=0.
- rxs is the last synchroniser stage. All FSM decisions use rxs only.
- Baud counter: cnt counts down to 0; "tick" means cnt==0.
- IDLE: if rxs==0, load cnt=DIV/2-1 and go to START.
- START: on tick, resample rxs. If 0, load cnt=DIV-1, set bit index=0, go to DATA. If 1, treat as a glitch and return to IDLE with no error.
- DATA: on each tick, shift rxs into the shift register LSB-first and reload cnt=DIV-1. After bit 7, go to STOP.
- STOP: on tick:
  - rxs==1: push the byte (or raise overflow if no slot), go to IDLE.
  - rxs==0: frame_err pulse, byte discarded, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then IDLE. This prevents a break condition from retriggering reception.
- Push acceptance: a push succeeds when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle. Otherwise the byte is dropped and overflow pulses; FIFO contents are unchanged.
- Latency:
  - A byte pushed in cycle N is visible at rx_data with rx_valid=1 in cycle N+1.
  - Pin-to-valid latency = SYNC_STAGES + DIV/2 + 9*DIV + 1 cycles after the start-bit falling edge.
- FIFO:
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked by rx_count.
  - Simultaneous push and pop leaves rx_count unchanged.
  - Pop when empty is ignored.
- rx_data and rx_valid must remain stable while rx_valid=1 and rx_ready=0.
- RESET asserted mid-frame aborts the frame and flushes the FIFO. The next frame requires a fresh falling edge.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined:
  - Adds a PARITY state between DATA and STOP. It samples one even-parity bit on a tick.
  - Adds output port parity_err (1 bit).
  - At STOP with a good stop bit and a parity mismatch: parity_err pulses for one cycle, the byte is discarded, overflow is not asserted.
  - Frame length becomes 11 bits; latency grows by DIV.
- Not defined: 8N1 only, no parity_err port, no PARITY state.

Test Plan:
(All scenarios use default parameters, DIV=434.)
1. Send 0xA5 8N1 with rx_ready=1 -> rx_valid pulses one cycle with rx_data=0xA5; valid rises 2+217+3906+1 cycles after the start edge; no error pulses.
2. Low glitch of 100 cycles on an idle line -> FSM returns to IDLE; no push, no frame_err; a following 0x3C is received correctly.
3. Frame 0x55 with stop bit forced 0, line held low for 2000 cycles, then high -> exactly one frame_err pulse, FIFO empty, no spurious second frame; a subsequent 0x81 is received.
4. rx_ready=0, send bytes 0x00..0x10 (17 bytes) -> rx_count=16, one overflow pulse on byte 0x10; after draining, the bytes read are 0x00..0x0F in order.
5. FIFO full, then push and pop in the same cycle (rx_ready=1 on the stop tick of the 17th byte) -> no overflow, rx_count stays 16, new byte is at the tail.
6. Assert RESET for 1 cycle halfway through the DATA bits of 0xF0 -> outputs return to reset values, FIFO empty; the remaining bits are not captured as a byte; the next frame 0x0F is received.
